// File: rtl/seg_scan_controller.sv
// seg_scan_controller: self-timed multiplexer for an N-digit common-anode
// 7-segment display. It generates its own scan timing and latches the
// displayed digits once per frame. It also provides leading-zero blanking,
// per-digit decimal points and PWM brightness. All outputs are registered.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_PRIME | out of reset, shadow not yet loaded; first enabled cycle loads it
// ST_SCAN  | normal scanning, shadow reloads only when the index wraps to 0

module seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int PRESCALE   = 1000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [DIGIT_W-1:0]            digit,
    output logic [NUM_DIGITS-1:0]         select,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic                          frame_start
);

    localparam int DW = NUM_DIGITS * DIGIT_W;
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_PRIME, ST_SCAN} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
    logic [DIGIT_W-1:0]      digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   select_q, select_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q, fs_d;

    logic [DW-1:0]           src;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [DIGIT_W-1:0]      cur_digit;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    zf;
    logic                    blank;
    logic                    lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    generate
        if (DIGIT_W >= 4) begin : g_nib
            assign nib = cur_digit[3:0];
        end else begin : g_nib_ext
            assign nib = {{(4 - DIGIT_W){1'b0}}, cur_digit};
        end
    endgenerate

    // Data view for the slot being scanned: on the priming cycle the
    // shadow is loaded this edge, so show the incoming data directly.
    always_comb begin
        src       = (state_q == ST_PRIME) ? data  : shadow_q;
        src_dp    = (state_q == ST_PRIME) ? dp_in : sdp_q;
        cur_digit = src[idx_q*DIGIT_W +: DIGIT_W];
        zero_from = '0;
        zf        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (src[i*DIGIT_W +: DIGIT_W] != '0) begin
                zf = 1'b0;
            end
            zero_from[i] = zf;
        end
        blank = blank_lz && (idx_q != '0) && zero_from[idx_q];
        lit   = !blank && (pcnt_q[BRIGHT_W-1:0] <= brightness);
    end

    // Next-state: prescaler/index advance, frame-synchronous shadow load
    // and the registered display outputs for the current slot.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        digit_d  = digit_q;
        select_d = '0;
        an_d     = '1;
        seg_d    = 7'b1111111;
        dp_d     = 1'b1;
        fs_d     = 1'b0;

        if (enable) begin
            if (state_q == ST_PRIME) begin
                shadow_d = data;
                sdp_d    = dp_in;
                state_d  = ST_SCAN;
            end

            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    shadow_d = data;
                    sdp_d    = dp_in;
                    fs_d     = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end

            digit_d  = cur_digit;
            select_d = NUM_DIGITS'(1) << idx_q;
            an_d     = lit ? ~select_d : '1;
            seg_d    = blank ? 7'b1111111 : hex7(nib);
            dp_d     = blank | ~src_dp[idx_q];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_PRIME;
            pcnt_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sdp_q    <= '0;
            digit_q  <= '0;
            select_q <= '0;
            an_q     <= '1;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            digit_q  <= digit_d;
            select_q <= select_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            fs_q     <= fs_d;
        end
    end

    assign digit       = digit_q;
    assign select      = select_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller (4 digits, 4-bit digits, 4-cycle slots,
// 2-bit brightness) against a cycle-level behavioural model.

module tb_seg_scan_controller;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int P  = 4;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          enable;
    logic [15:0]   data;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic [3:0]    digit;
    logic [3:0]    select;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    seg_scan_controller #(
        .NUM_DIGITS(N), .DIGIT_W(W), .PRESCALE(P), .BRIGHT_W(BW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .data(data),
        .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
        .digit(digit), .select(select), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start)
    );

    int total = 0;
    int bad   = 0;

    // model state: slot counter, digit index, latched frame contents
    int   m_pcnt;
    int   m_idx;
    bit   m_started;
    int   fr [N];
    bit   fdp [N];
    logic [3:0]  e_digit;
    logic [20:0] exp_v;

    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [20:0] obs();
        return {digit, select, an, seg, dp, frame_start};
    endfunction

    task automatic capture();
        for (int i = 0; i < N; i++) begin
            fr[i]  = int'(data[i*W +: W]);
            fdp[i] = dp_in[i];
        end
    endtask

    // Predict what the outputs show after the coming edge, update the
    // model, then advance one clock and settle.
    task automatic tick();
        logic [3:0] sel, anv;
        logic [6:0] sg;
        logic       d, fs;
        bit         blank, lit;
        fs = 1'b0;
        if (!reset_n) begin
            m_pcnt = 0; m_idx = 0; m_started = 0;
            for (int i = 0; i < N; i++) begin fr[i] = 0; fdp[i] = 0; end
            e_digit = 4'h0;
            sel = 4'h0; anv = 4'hF; sg = 7'h7F; d = 1'b1;
        end else if (!enable) begin
            sel = 4'h0; anv = 4'hF; sg = 7'h7F; d = 1'b1;
        end else begin
            if (!m_started) begin
                capture();
                m_started = 1;
            end
            blank = 0;
            if (blank_lz && m_idx > 0) begin
                blank = 1;
                for (int j = m_idx; j < N; j++) if (fr[j] != 0) blank = 0;
            end
            lit     = !blank && ((m_pcnt % (1 << BW)) <= int'(brightness));
            sel     = 4'(1 << m_idx);
            anv     = lit ? ~sel : 4'hF;
            sg      = blank ? 7'h7F : segtab[fr[m_idx]];
            d       = blank ? 1'b1 : !fdp[m_idx];
            e_digit = 4'(fr[m_idx]);
            m_pcnt++;
            if (m_pcnt == P) begin
                m_pcnt = 0;
                m_idx++;
                if (m_idx == N) begin
                    m_idx = 0;
                    capture();
                    fs = 1'b1;
                end
            end
        end
        exp_v = {e_digit, sel, anv, sg, d, fs};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; data = 16'h1234; dp_in = 4'h0;
        blank_lz = 1'b0; brightness = 2'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        total++;
        if (obs() !== {4'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", obs(), {4'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
        end
    endtask

    task automatic test_scan();
        int fs_count = 0;
        reset_n = 1'b1;
        for (int c = 0; c < 48; c++) begin
            tick();
            if (frame_start) fs_count++;
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL scan cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        total++;
        if (fs_count != 3) begin
            bad++;
            $display("FAIL scan_frame_count got=%0d exp=3", fs_count);
        end
    endtask

    task automatic test_no_tearing();
        int guard = 0;
        int a_seen = 0;
        while (!(m_idx == 1 && m_pcnt == 1) && guard < 40) begin
            tick();
            guard++;
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL tear_pre cyc=%0d got=%h exp=%h", guard, obs(), exp_v);
            end
        end
        if (guard >= 40) begin
            total++; bad++;
            $display("FAIL tear_sync timeout got=%0d exp=<40", guard);
        end
        data = 16'hABCD;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (select == 4'b1000 && seg == 7'b0001000) a_seen++;
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL tear cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        total++;
        if (a_seen != 4) begin
            bad++;
            $display("FAIL tear_digitA_cycles got=%0d exp=4", a_seen);
        end
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        data = 16'h0070;
        for (int c = 0; c < 36; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL blank70 cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        data = 16'h0000;
        dp_in = 4'b1110;
        for (int c = 0; c < 36; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL blank00 cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        blank_lz = 1'b0;
        dp_in = 4'h0;
        data = 16'h5A0F;
    endtask

    task automatic test_pwm();
        for (int b = 0; b < 4; b++) begin
            brightness = 2'(b);
            for (int c = 0; c < 20; c++) begin
                tick();
                total++;
                if (obs() !== exp_v) begin
                    bad++;
                    $display("FAIL pwm b=%0d cyc=%0d got=%h exp=%h", b, c, obs(), exp_v);
                end
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_enable_hold();
        int guard = 0;
        while (!(m_idx == 2 && m_pcnt == 1) && guard < 40) begin
            tick();
            guard++;
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL hold_pre cyc=%0d got=%h exp=%h", guard, obs(), exp_v);
            end
        end
        if (guard >= 40) begin
            total++; bad++;
            $display("FAIL hold_sync timeout got=%0d exp=<40", guard);
        end
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL hold_off cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL hold_resume cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
    endtask

    task automatic test_reset_midframe();
        dp_in = 4'b0100;
        for (int c = 0; c < 22; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        reset_n = 1'b0;
        tick();
        total++;
        if (obs() !== exp_v) begin
            bad++;
            $display("FAIL rstmid_pulse got=%h exp=%h", obs(), exp_v);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            enable  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                data = 16'($urandom);
                if ($urandom_range(0, 1) == 0) data[15:8] = 8'h00;
            end
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            tick();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_blanking();
        test_pwm();
        test_enable_hold();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
